// File: rtl/mem_access_ctrl.sv
// Data-memory access initiator for a multicycle CPU.
// Takes one load/store request at a time, rejects misaligned addresses,
// and sequences SETUP -> ACCESS -> HOLD so the level-sensitive strobes are
// only high while address, data and size are already stable.
module mem_access_ctrl #(
    parameter int ACCESS_CYCLES = 1,
    parameter int ADDR_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] bad_addr,
    output logic [31:0]       ld_data,
    output logic              MEM_W,
    output logic              MEM_R,
    output logic              MEM_S,
    output logic [1:0]        MEM_C,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] OP_LW  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LHU = 3'b010;
    localparam logic [2:0] OP_LB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_SW  = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SB  = 3'b111;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    localparam logic [3:0] CNT_INIT = 4'(ACCESS_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        op_store;
    logic        err_r;
    logic        accept;
    logic        last_access;

    // Decoded view of the incoming request.
    logic [1:0]  dec_size;
    logic        dec_sext;
    logic        dec_store;
    logic        dec_misaligned;

    assign accept      = req_valid && req_ready;
    assign last_access = (state == ACCESS) && (cnt <= 4'd1);
    assign err         = done && err_r;

    // Decode op into size, sign-extension, direction and alignment fault.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an unlisted case path infers a latch.
        dec_size       = SIZE_WORD;
        dec_sext       = 1'b0;
        dec_store      = 1'b0;
        dec_misaligned = 1'b0;
        unique case (req_op)
            OP_LW:  dec_misaligned = |req_addr[1:0];
            OP_LH:  begin dec_size = SIZE_HALF; dec_sext = 1'b1; dec_misaligned = req_addr[0]; end
            OP_LHU: begin dec_size = SIZE_HALF; dec_misaligned = req_addr[0]; end
            OP_LB:  begin dec_size = SIZE_BYTE; dec_sext = 1'b1; end
            OP_LBU: dec_size = SIZE_BYTE;
            OP_SW:  begin dec_store = 1'b1; dec_misaligned = |req_addr[1:0]; end
            OP_SH:  begin dec_store = 1'b1; dec_size = SIZE_HALF; dec_misaligned = req_addr[0]; end
            OP_SB:  begin dec_store = 1'b1; dec_size = SIZE_BYTE; end
            default: ;
        endcase
    end

    // State register; async reset drops the strobes without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state is always assigned with <= so every flop
        // samples the pre-edge value of its neighbours.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state and strobe/handshake decode; strobes are a pure function of state.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        done      = 1'b0;
        MEM_R     = 1'b0;
        MEM_W     = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = dec_misaligned ? DONE : SETUP;
            end
            SETUP:  state_nxt = ACCESS;
            ACCESS: begin
                MEM_W = op_store;
                MEM_R = !op_store;
                if (cnt <= 4'd1) state_nxt = HOLD;
            end
            HOLD:   state_nxt = DONE;
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture, access-length counter and load-data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r     <= 1'b0;
            bad_addr  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            MEM_C     <= SIZE_WORD;
            MEM_S     <= 1'b0;
            op_store  <= 1'b0;
            cnt       <= '0;
            ld_data   <= '0;
        end else begin
            // A rejected request leaves the memory-side bus untouched.
            if (accept) begin
                err_r <= dec_misaligned;
                if (dec_misaligned) begin
                    bad_addr <= req_addr;
                end else begin
                    mem_addr  <= req_addr;
                    mem_wdata <= req_wdata;
                    MEM_C     <= dec_size;
                    MEM_S     <= dec_sext;
                    op_store  <= dec_store;
                end
            end

            // Count down to 1 and stop there, so the counter never wraps.
            if (state == SETUP)
                cnt <= CNT_INIT;
            else if (state == ACCESS && cnt > 4'd1)
                cnt <= cnt - 4'd1;

            if (last_access && !op_store)
                ld_data <= mem_rdata;
        end
    end

    a_cycles_legal: assert property (@(posedge clk) disable iff (rst)
        (ACCESS_CYCLES >= 1 && ACCESS_CYCLES <= 15))
        else $error("ACCESS_CYCLES must be in 1..15");

    a_strobes_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(MEM_R && MEM_W))
        else $error("MEM_R and MEM_W asserted together");

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: a table of single transactions on an
// ACCESS_CYCLES=1 instance, plus hand-written multi-cycle and reset sequences
// on ACCESS_CYCLES=3 and ACCESS_CYCLES=1 instances.
module tb_mem_access_ctrl;

    localparam int ACC1 = 1;
    localparam int ACC3 = 3;

    localparam logic [2:0] LW  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LHU = 3'b010;
    localparam logic [2:0] LB  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] SW  = 3'b101;
    localparam logic [2:0] SH  = 3'b110;
    localparam logic [2:0] SB  = 3'b111;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem_word;
        logic [31:0] exp_ld;
        logic        exp_err;
        logic [1:0]  exp_c;
        logic        exp_s;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req_op = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;

    logic        valid1 = 1'b0, ready1, done1, err1, w1, r1, s1;
    logic [1:0]  c1;
    logic [31:0] bad1, ld1, maddr1, wdata1, rdata1;

    logic        valid3 = 1'b0, ready3, done3, err3, w3, r3, s3;
    logic [1:0]  c3;
    logic [31:0] bad3, ld3, maddr3, wdata3, rdata3;

    logic [31:0] mem [0:63];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ACCESS_CYCLES(ACC1), .ADDR_W(32)) dut1 (
        .clk(clk), .rst(rst), .req_valid(valid1), .req_ready(ready1),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .done(done1), .err(err1), .bad_addr(bad1), .ld_data(ld1),
        .MEM_W(w1), .MEM_R(r1), .MEM_S(s1), .MEM_C(c1),
        .mem_addr(maddr1), .mem_wdata(wdata1), .mem_rdata(rdata1)
    );

    mem_access_ctrl #(.ACCESS_CYCLES(ACC3), .ADDR_W(32)) dut3 (
        .clk(clk), .rst(rst), .req_valid(valid3), .req_ready(ready3),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .done(done3), .err(err3), .bad_addr(bad3), .ld_data(ld3),
        .MEM_W(w3), .MEM_R(r3), .MEM_S(s3), .MEM_C(c3),
        .mem_addr(maddr3), .mem_wdata(wdata3), .mem_rdata(rdata3)
    );

    // Memory model: selects the lane and extends it from MEM_C/MEM_S/address.
    function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] lo,
                                           input logic [1:0] c, input logic s);
        logic [15:0] h;
        logic [7:0]  b;
        h = lo[1] ? w[31:16] : w[15:0];
        case (lo)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        case (c)
            2'b01:   return s ? {{16{h[15]}}, h} : {16'h0, h};
            2'b10:   return s ? {{24{b[7]}}, b} : {24'h0, b};
            default: return w;
        endcase
    endfunction

    always_comb rdata1 = extend(mem[maddr1[7:2]], maddr1[1:0], c1, s1);
    always_comb rdata3 = extend(mem[maddr3[7:2]], maddr3[1:0], c3, s3);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction on dut1, observed cycle by cycle after acceptance.
    task automatic run1(input string tag, input vec_t v);
        int   done_cyc, rcnt, wcnt, first_strobe;
        logic err_seen, strobe_bad, frame_bad, waited, is_store;
        is_store     = (v.op >= SW);
        done_cyc     = -1;
        rcnt         = 0;
        wcnt         = 0;
        first_strobe = -1;
        err_seen     = 1'b0;
        strobe_bad   = 1'b0;
        frame_bad    = 1'b0;
        waited       = 1'b0;
        mem[v.addr[7:2]] = v.mem_word;
        for (int i = 0; i < 20; i++) begin
            if (ready1) begin waited = 1'b1; break; end
            tick();
        end
        check({tag, " ready_before_req"}, waited, 1'b1);
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        valid1    = 1'b1;
        tick();
        valid1 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (r1) begin rcnt++; if (first_strobe < 0) first_strobe = c; end
            if (w1) begin wcnt++; if (first_strobe < 0) first_strobe = c; end
            if ((r1 || w1) && (c1 !== v.exp_c || s1 !== v.exp_s || maddr1 !== v.addr))
                strobe_bad = 1'b1;
            if (!v.exp_err && (c == 1 || c == ACC1 + 2)) begin
                if (r1 || w1 || maddr1 !== v.addr || c1 !== v.exp_c || s1 !== v.exp_s ||
                    (is_store && wdata1 !== v.wdata))
                    frame_bad = 1'b1;
            end
            if (done1) begin done_cyc = c; err_seen = err1; break; end
            tick();
        end
        check({tag, " done_cycle"}, done_cyc, v.exp_err ? 1 : ACC1 + 3);
        check({tag, " err"}, err_seen, v.exp_err);
        check({tag, " mem_r_cycles"}, rcnt, (!is_store && !v.exp_err) ? ACC1 : 0);
        check({tag, " mem_w_cycles"}, wcnt, (is_store && !v.exp_err) ? ACC1 : 0);
        if (!v.exp_err) check({tag, " first_strobe_cycle"}, first_strobe, 2);
        check({tag, " strobe_attrs"}, strobe_bad, 1'b0);
        check({tag, " setup_hold_stable"}, frame_bad, 1'b0);
        check({tag, " ld_data"}, ld1, v.exp_ld);
        if (v.exp_err) check({tag, " bad_addr"}, bad1, v.addr);
        tick();
    endtask

    vec_t vecs [13];

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int   rmask, first_done, second_done, no_done_bad;
        logic rdy_bad, addr_bad, rdy7;
        logic [31:0] ld_first;

        //           op   addr          wdata         mem_word      exp_ld        err   C      S
        vecs[0]  = '{LW,  32'h0000_0010, 32'h0,        32'h1234_5678, 32'h1234_5678, 1'b0, 2'b00, 1'b0};
        vecs[1]  = '{SB,  32'h0000_0013, 32'hAABB_CCDD, 32'h1234_5678, 32'h1234_5678, 1'b0, 2'b10, 1'b0};
        vecs[2]  = '{LH,  32'h0000_0020, 32'h0,        32'h0000_8001, 32'hFFFF_8001, 1'b0, 2'b01, 1'b1};
        vecs[3]  = '{LHU, 32'h0000_0020, 32'h0,        32'h0000_8001, 32'h0000_8001, 1'b0, 2'b01, 1'b0};
        vecs[4]  = '{SW,  32'h0000_0022, 32'h1111_2222, 32'h0000_8001, 32'h0000_8001, 1'b1, 2'b00, 1'b0};
        vecs[5]  = '{LW,  32'h0000_0024, 32'h0,        32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 2'b00, 1'b0};
        vecs[6]  = '{LB,  32'h0000_0017, 32'h0,        32'h9A00_0000, 32'hFFFF_FF9A, 1'b0, 2'b10, 1'b1};
        vecs[7]  = '{LBU, 32'h0000_0017, 32'h0,        32'h9A00_0000, 32'h0000_009A, 1'b0, 2'b10, 1'b0};
        vecs[8]  = '{LH,  32'h0000_0023, 32'h0,        32'h0,         32'h0000_009A, 1'b1, 2'b01, 1'b1};
        vecs[9]  = '{SH,  32'h0000_002A, 32'h0000_BEEF, 32'h0,         32'h0000_009A, 1'b0, 2'b01, 1'b0};
        vecs[10] = '{LHU, 32'h0000_0026, 32'h0,        32'hCAFE_F00D, 32'h0000_CAFE, 1'b0, 2'b01, 1'b0};
        vecs[11] = '{LW,  32'h0000_001E, 32'h0,        32'h0,         32'h0000_CAFE, 1'b1, 2'b00, 1'b0};
        vecs[12] = '{SH,  32'h0000_0031, 32'h0000_1234, 32'h0,         32'h0000_CAFE, 1'b1, 2'b01, 1'b0};

        for (int i = 0; i < 64; i++) mem[i] = '0;

        // Reset values, observed while rst is still high.
        #3;
        check("rst req_ready", ready1, 1'b1);
        check("rst done", done1, 1'b0);
        check("rst err", err1, 1'b0);
        check("rst strobes", {w1, r1}, 2'b00);
        check("rst mem_s_c", {s1, c1}, 3'b000);
        check("rst mem_addr", maddr1, 32'h0);
        check("rst mem_wdata", wdata1, 32'h0);
        check("rst ld_data", ld1, 32'h0);
        check("rst bad_addr", bad1, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        foreach (vecs[i]) run1($sformatf("vec%0d", i), vecs[i]);

        // ACCESS_CYCLES=3 LB: three-cycle MEM_R, capture on the last, request held meanwhile.
        mem[12] = 32'h0000_0011;
        mem[16] = 32'h5555_AAAA;
        rmask = 0; first_done = -1; second_done = -1;
        rdy_bad = 1'b0; addr_bad = 1'b0; rdy7 = 1'b0; ld_first = '0;
        req_op = LB; req_addr = 32'h30; req_wdata = '0; valid3 = 1'b1;
        tick();
        req_op = LW; req_addr = 32'h40;
        for (int c = 1; c <= 16; c++) begin
            if (c == 2) mem[12] = 32'h0000_0011;
            if (c == 3) mem[12] = 32'h0000_0022;
            if (c == 4) mem[12] = 32'h0000_0080;
            if (c == 8) valid3 = 1'b0;
            if (r3 && c <= 6) rmask = rmask | (1 << c);
            if (c <= 6 && ready3) rdy_bad = 1'b1;
            if (c == 7) rdy7 = ready3;
            if (c >= 1 && c <= 5 && maddr3 !== 32'h30) addr_bad = 1'b1;
            if (done3) begin
                if (first_done < 0) begin first_done = c; ld_first = ld3; end
                else second_done = c;
            end
            if (second_done > 0) break;
            tick();
        end
        check("acc3 mem_r_pattern", rmask, 32'b111_0000 >> 2 << 0 | 0);
        check("acc3 first_done_cycle", first_done, 6);
        check("acc3 lb_captured_last", ld_first, 32'hFFFF_FF80);
        check("acc3 ready_low_while_busy", rdy_bad, 1'b0);
        check("acc3 held_req_ignored_addr", addr_bad, 1'b0);
        check("acc3 ready_back_cycle7", rdy7, 1'b1);
        check("acc3 second_done_cycle", second_done, 13);
        check("acc3 second_ld", ld3, 32'h5555_AAAA);
        valid3 = 1'b0;
        tick();

        // Reset pulsed during the ACCESS cycle of a store.
        req_op = SW; req_addr = 32'h50; req_wdata = 32'h0000_0001; valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        tick();
        check("rstmid mem_w_before", w1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid mem_w_dropped", w1, 1'b0);
        check("rstmid req_ready", ready1, 1'b1);
        check("rstmid done", done1, 1'b0);
        #1;
        rst = 1'b0;
        no_done_bad = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (done1 || w1) no_done_bad++;
        end
        check("rstmid no_done_after", no_done_bad, 0);
        run1("post_rst_lw", '{LW, 32'h10, 32'h0, 32'h1234_5678, 32'h1234_5678, 1'b0, 2'b00, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
